// File: rtl/dco_pkg.sv
// Shared types for the dithered DCO: control FSM states and the tap-range helper.
package dco_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RUN    = 2'd2
  } dco_state_e;

  function automatic int TAP_MAX(input int ctrl_width);
    return (1 << ctrl_width) - 1;
  endfunction

endpackage

// File: rtl/dco_ring.sv
// DONT_TOUCH ring: one enable NAND plus RINGSIZE-1 inverters; tap t closes the loop 2t stages early.
// SYNTHESIS selects the closed loop; otherwise the loop is opened so zero-delay simulators settle.
module dco_ring
  import dco_pkg::*;
#(
  parameter int RINGSIZE   = 421,
  parameter int CTRL_WIDTH = 5
) (
  input  logic                  ring_en_i,
  input  logic                  ring_reset_i,
  input  logic [CTRL_WIDTH-1:0] tap_i,
  output logic                  clk_o
);

  localparam int TAP_LAST = TAP_MAX(CTRL_WIDTH);

  logic [TAP_LAST:0] tap_nodes;
  logic              ring_on;
  logic              tap_node;
  logic              fb;

  assign ring_on  = ring_en_i & ~ring_reset_i;
  assign tap_node = tap_nodes[tap_i];
  // Gated ring: feedback forced low so the NAND parks the chain at a static level.
  assign fb       = ring_on & tap_node;

  genvar gi;
  generate
    for (gi = 0; gi < RINGSIZE; gi++) begin : g_stage
      (* DONT_TOUCH = "yes" *) logic n;
      if (gi == 0) begin : g_nand
`ifdef SYNTHESIS
        assign n = ~(ring_on & fb);
`else
        assign n = ~ring_on;
`endif
      end else begin : g_inv
        assign n = ~g_stage[gi-1].n;
      end
    end

    // An even number of inverters is removed per tap, so the loop stays odd.
    for (gi = 0; gi <= TAP_LAST; gi++) begin : g_tap
      assign tap_nodes[gi] = g_stage[RINGSIZE-1-2*gi].n;
    end
  endgenerate

`ifdef SYNTHESIS
  assign clk_o = g_stage[0].n;
`else
  assign clk_o = g_stage[0].n | fb;
`endif

endmodule

// File: rtl/dco_dither_ring.sv
// DCO control: settle FSM, one-code-per-edge coarse slew and first-order sigma-delta tap dither.
// Define DCO_DITHER_EN to build the fractional dither path (fine word + accumulator).
module dco_dither_ring
  import dco_pkg::*;
#(
  parameter int RINGSIZE      = 421,
  parameter int CTRL_WIDTH    = 5,
  parameter int FRAC_WIDTH    = 8,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  enable_i,
  input  logic                  load_i,
  input  logic [CTRL_WIDTH-1:0] coarse_i,
  input  logic [FRAC_WIDTH-1:0] fine_i,
  output logic                  clk_o,
  output logic                  ready_o,
  output logic                  busy_o,
  output logic [CTRL_WIDTH-1:0] tap_o
);

  localparam int                    CNT_W        = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]      SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CTRL_WIDTH-1:0] TAP_MAX_CODE = CTRL_WIDTH'(TAP_MAX(CTRL_WIDTH));

  dco_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CTRL_WIDTH-1:0] target_q, target_d;
  logic [CTRL_WIDTH-1:0] cur_q, cur_d;
  logic [CTRL_WIDTH-1:0] tap_q, tap_d;
  logic [CTRL_WIDTH:0]   tap_sum;
  logic                  carry;

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      IDLE:   if (enable_i) state_d = SETTLE;
      SETTLE: begin
        if (!enable_i)                 state_d = IDLE;
        else if (cnt_q == SETTLE_LAST) state_d = RUN;
        else                           cnt_d   = cnt_q + 1'b1;
      end
      RUN:    if (!enable_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The slew steps toward the target held before this edge, so a retarget
  // simply redirects the walk from wherever cur_q is now.
  always_comb begin
    target_d = load_i ? coarse_i : target_q;
    cur_d    = cur_q;
    if (cur_q < target_q)      cur_d = cur_q + 1'b1;
    else if (cur_q > target_q) cur_d = cur_q - 1'b1;
  end

`ifdef DCO_DITHER_EN
  logic [FRAC_WIDTH-1:0] fine_q, fine_d;
  logic [FRAC_WIDTH-1:0] acc_q, acc_d;
  logic [FRAC_WIDTH:0]   acc_sum;
  logic                  run_active;

  assign run_active = (state_q == RUN) && enable_i;
  assign acc_sum    = {1'b0, acc_q} + {1'b0, fine_q};
  assign carry      = run_active & acc_sum[FRAC_WIDTH];

  always_comb begin
    fine_d = load_i ? fine_i : fine_q;
    acc_d  = run_active ? acc_sum[FRAC_WIDTH-1:0] : '0;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      fine_q <= '0;
      acc_q  <= '0;
    end else begin
      fine_q <= fine_d;
      acc_q  <= acc_d;
    end
  end
`else
  logic unused_fine;
  assign unused_fine = ^fine_i;
  assign carry       = 1'b0;
`endif

  // Carry into the top code saturates rather than wrapping to the slowest tap.
  assign tap_sum = {1'b0, cur_q} + {{CTRL_WIDTH{1'b0}}, carry};
  assign tap_d   = tap_sum[CTRL_WIDTH] ? TAP_MAX_CODE : tap_sum[CTRL_WIDTH-1:0];

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      target_q <= '0;
      cur_q    <= '0;
      tap_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
      cur_q    <= cur_d;
      tap_q    <= tap_d;
    end
  end

  assign ready_o = (state_q == RUN);
  assign busy_o  = (cur_q != target_q);
  assign tap_o   = tap_q;

  dco_ring #(
    .RINGSIZE   (RINGSIZE),
    .CTRL_WIDTH (CTRL_WIDTH)
  ) u_ring (
    .ring_en_i    (state_q != IDLE),
    .ring_reset_i (reset_i),
    .tap_i        (tap_q),
    .clk_o        (clk_o)
  );

endmodule
